rob_commit: RTL and testbench

- In-order retire/commit engine: the reader end of the reorder buffer that the allocation logic writes.
- Tracks the ROB head pointer and reads the two oldest entries through a combinational read port.
- Retires up to 2 completed entries per cycle, releases old physical destination registers to the free list, and gates store commits through a request/ack handshake with the store queue.

---
 rtl/rob_commit_if.sv | 44 ++++
 rtl/rob_commit.sv | 84 ++++++++
 tb/tb_rob_commit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// Bundle between the in-order commit engine and the ROB storage, allocator,
// store queue and free list. The master modport is the commit engine side.
interface rob_commit_if #(
  parameter int IDX_W  = 6,
  parameter int PREG_W = 6
);
  logic [IDX_W:0]  rob_tail;
  logic [IDX_W:0]  rob_head;
  logic [IDX_W-1:0] rd_idx0;
  logic [IDX_W-1:0] rd_idx1;
  logic            rd_complete0;
  logic            rd_complete1;
  logic            rd_is_store0;
  logic            rd_is_store1;
  logic [PREG_W-1:0] rd_old_dest0;
  logic [PREG_W-1:0] rd_old_dest1;
  logic [31:0]     rd_pc0;
  logic [31:0]     rd_pc1;
  logic            store_commit_req;
  logic [IDX_W-1:0] store_commit_idx;
  logic            store_commit_ack;
  logic [1:0]      retire_valid;
  logic [PREG_W-1:0] free_preg0;
  logic [PREG_W-1:0] free_preg1;
  logic [31:0]     retire_pc0;
  logic [31:0]     retire_pc1;
  logic [31:0]     retired_count;

  modport master (
    input  rob_tail, rd_complete0, rd_complete1, rd_is_store0, rd_is_store1,
           rd_old_dest0, rd_old_dest1, rd_pc0, rd_pc1, store_commit_ack,
    output rob_head, rd_idx0, rd_idx1, store_commit_req, store_commit_idx,
           retire_valid, free_preg0, free_preg1, retire_pc0, retire_pc1,
           retired_count
  );

  modport slave (
    output rob_tail, rd_complete0, rd_complete1, rd_is_store0, rd_is_store1,
           rd_old_dest0, rd_old_dest1, rd_pc0, rd_pc1, store_commit_ack,
    input  rob_head, rd_idx0, rd_idx1, store_commit_req, store_commit_idx,
           retire_valid, free_preg0, free_preg1, retire_pc0, retire_pc1,
           retired_count
  );
endinterface

// File: rtl/rob_commit.sv
// In-order ROB retire engine: retires up to two completed entries per cycle
// and serialises store commits through a req/ack handshake with the store queue.
module rob_commit #(
  parameter int ROB_DEPTH = 64,
  parameter int IDX_W     = 6,
  parameter int PREG_W    = 6
) (
  input  logic clk,
  input  logic rst,
  rob_commit_if.master rif
);

  typedef enum logic {
    RUN        = 1'b0,
    STORE_WAIT = 1'b1
  } state_t;

  state_t          state_q;
  logic [IDX_W:0]  head_q;
  logic [IDX_W:0]  occ;
  logic            elig0;
  logic            take1;

  // Wrap bit in the MSB makes full (occ==ROB_DEPTH) distinct from empty.
  assign occ   = rif.rob_tail - head_q;
  assign elig0 = (occ != '0) && rif.rd_complete0;
  assign take1 = (occ >= (IDX_W+1)'(2)) && rif.rd_complete1 && !rif.rd_is_store1;

  assign rif.rd_idx0  = head_q[IDX_W-1:0];
  assign rif.rd_idx1  = head_q[IDX_W-1:0] + IDX_W'(1);
  assign rif.rob_head = head_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q              <= RUN;
      head_q               <= '0;
      rif.retire_valid     <= '0;
      rif.free_preg0       <= '0;
      rif.free_preg1       <= '0;
      rif.retire_pc0       <= '0;
      rif.retire_pc1       <= '0;
      rif.store_commit_req <= 1'b0;
      rif.store_commit_idx <= '0;
      rif.retired_count    <= '0;
    end else begin
      // NOTE: non-blocking default first; a later assignment in the same block
      // overrides it, so retire_valid pulses for exactly the cycles that retire.
      rif.retire_valid <= 2'b00;
      unique case (state_q)
        RUN: begin
          if (elig0 && !rif.rd_is_store0) begin
            rif.retire_valid <= {take1, 1'b1};
            rif.free_preg0   <= rif.rd_old_dest0;
            rif.retire_pc0   <= rif.rd_pc0;
            if (take1) begin
              rif.free_preg1 <= rif.rd_old_dest1;
              rif.retire_pc1 <= rif.rd_pc1;
            end
            head_q            <= head_q + (take1 ? (IDX_W+1)'(2) : (IDX_W+1)'(1));
            rif.retired_count <= rif.retired_count + (take1 ? 32'd2 : 32'd1);
          end else if (elig0) begin
            // The store retires only once the store queue has taken it.
            rif.store_commit_req <= 1'b1;
            rif.store_commit_idx <= rif.rd_idx0;
            state_q              <= STORE_WAIT;
          end
        end
        STORE_WAIT: begin
          if (rif.store_commit_ack) begin
            rif.retire_valid     <= 2'b01;
            rif.free_preg0       <= rif.rd_old_dest0;
            rif.retire_pc0       <= rif.rd_pc0;
            head_q               <= head_q + (IDX_W+1)'(1);
            rif.retired_count    <= rif.retired_count + 32'd1;
            rif.store_commit_req <= 1'b0;
            state_q              <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: a ROB storage model answers the read port,
// and expected retire results are queued at stimulus time and checked after each edge.
module tb_rob_commit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_commit_if rif ();

  rob_commit dut (
    .clk (clk),
    .rst (rst),
    .rif (rif)
  );

  // ROB contents as the allocator/execute side would hold them
  logic        rob_c [64];
  logic        rob_s [64];
  logic [5:0]  rob_d [64];
  logic [31:0] rob_p [64];

  always_comb begin
    rif.rd_complete0 = rob_c[rif.rd_idx0];
    rif.rd_is_store0 = rob_s[rif.rd_idx0];
    rif.rd_old_dest0 = rob_d[rif.rd_idx0];
    rif.rd_pc0       = rob_p[rif.rd_idx0];
    rif.rd_complete1 = rob_c[rif.rd_idx1];
    rif.rd_is_store1 = rob_s[rif.rd_idx1];
    rif.rd_old_dest1 = rob_d[rif.rd_idx1];
    rif.rd_pc1       = rob_p[rif.rd_idx1];
  end

  typedef struct packed {
    logic [1:0]  rv;
    logic [5:0]  f0;
    logic [5:0]  f1;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [6:0]  head;
    logic        req;
    logic [5:0]  sidx;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [6:0]  exp_head;
  logic [31:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic c, input logic s,
                           input logic [5:0] d, input logic [31:0] p);
    rob_c[idx] = c;
    rob_s[idx] = s;
    rob_d[idx] = d;
    rob_p[idx] = p;
  endtask

  // Queue the outcome expected at the coming edge, advancing the head/count model.
  task automatic push(input logic [1:0] rv, input logic [5:0] f0, input logic [5:0] f1,
                      input logic [31:0] p0, input logic [31:0] p1,
                      input logic req, input logic [5:0] sidx);
    exp_t e;
    int   n;
    n        = int'(rv[0]) + int'(rv[1]);
    exp_head = exp_head + 7'(n);
    exp_cnt  = exp_cnt + 32'(n);
    e = '{rv: rv, f0: f0, f1: f1, p0: p0, p1: p1, head: exp_head,
          req: req, sidx: sidx, cnt: exp_cnt};
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("retire_valid", 32'(rif.retire_valid), 32'(e.rv));
      check("rob_head", 32'(rif.rob_head), 32'(e.head));
      check("store_commit_req", 32'(rif.store_commit_req), 32'(e.req));
      check("retired_count", rif.retired_count, e.cnt);
      if (e.req) check("store_commit_idx", 32'(rif.store_commit_idx), 32'(e.sidx));
      if (e.rv[0]) begin
        check("free_preg0", 32'(rif.free_preg0), 32'(e.f0));
        check("retire_pc0", rif.retire_pc0, e.p0);
      end
      if (e.rv[1]) begin
        check("free_preg1", 32'(rif.free_preg1), 32'(e.f1));
        check("retire_pc1", rif.retire_pc1, e.p1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_retire_valid"}, 32'(rif.retire_valid), 32'd0);
    check({tag, "_rob_head"}, 32'(rif.rob_head), 32'd0);
    check({tag, "_req"}, 32'(rif.store_commit_req), 32'd0);
    check({tag, "_sidx"}, 32'(rif.store_commit_idx), 32'd0);
    check({tag, "_free0"}, 32'(rif.free_preg0), 32'd0);
    check({tag, "_free1"}, 32'(rif.free_preg1), 32'd0);
    check({tag, "_pc0"}, rif.retire_pc0, 32'd0);
    check({tag, "_pc1"}, rif.retire_pc1, 32'd0);
    check({tag, "_count"}, rif.retired_count, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) set_entry(i, 1'b0, 1'b0, 6'd0, 32'd0);
    rst                  = 1'b1;
    rif.rob_tail         = 7'd0;
    rif.store_commit_ack = 1'b0;
    exp_head             = 7'd0;
    exp_cnt              = 32'd0;

    // Reset takes effect before any clock edge
    #2;
    check_reset_outputs("reset_async");
    @(negedge clk);
    rst = 1'b0;

    // Empty ROB: nothing retires
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0); step();

    // Single retire
    set_entry(0, 1'b1, 1'b0, 6'd12, 32'h100);
    rif.rob_tail = 7'd1;
    push(2'b01, 6'd12, 6'd0, 32'h100, 32'd0, 1'b0, 6'd0); step();
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0); step();

    // Dual retire
    set_entry(1, 1'b1, 1'b0, 6'd5, 32'h104);
    set_entry(2, 1'b1, 1'b0, 6'd9, 32'h108);
    rif.rob_tail = 7'd3;
    push(2'b11, 6'd5, 6'd9, 32'h104, 32'h108, 1'b0, 6'd0); step();

    // Strict in-order: head incomplete blocks a complete slot1
    set_entry(3, 1'b0, 1'b0, 6'd0, 32'd0);
    set_entry(4, 1'b1, 1'b0, 6'd7, 32'h110);
    rif.rob_tail = 7'd5;
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0); step();
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0); step();

    // Store at head idx 3, ack held off for three request cycles
    set_entry(3, 1'b1, 1'b1, 6'd20, 32'h10c);
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd3); step();
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd3); step();
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd3); step();
    rif.store_commit_ack = 1'b1;
    push(2'b01, 6'd20, 6'd0, 32'h10c, 32'd0, 1'b0, 6'd0); step();
    rif.store_commit_ack = 1'b0;
    push(2'b01, 6'd7, 6'd0, 32'h110, 32'd0, 1'b0, 6'd0); step();

    // Ack with no request outstanding is ignored
    rif.store_commit_ack = 1'b1;
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0); step();

    // Back-to-back stores with ack held high: each gets a fresh request
    set_entry(5, 1'b1, 1'b1, 6'd21, 32'h114);
    set_entry(6, 1'b1, 1'b1, 6'd22, 32'h118);
    rif.rob_tail = 7'd7;
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd5); step();
    push(2'b01, 6'd21, 6'd0, 32'h114, 32'd0, 1'b0, 6'd0); step();
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd6); step();
    push(2'b01, 6'd22, 6'd0, 32'h118, 32'd0, 1'b0, 6'd0); step();
    rif.store_commit_ack = 1'b0;

    // Store in slot1 does not retire alongside slot0
    set_entry(7, 1'b1, 1'b0, 6'd23, 32'h11c);
    set_entry(8, 1'b1, 1'b1, 6'd24, 32'h120);
    rif.rob_tail = 7'd9;
    push(2'b01, 6'd23, 6'd0, 32'h11c, 32'd0, 1'b0, 6'd0); step();
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd8); step();
    rif.store_commit_ack = 1'b1;
    push(2'b01, 6'd24, 6'd0, 32'h120, 32'd0, 1'b0, 6'd0); step();
    rif.store_commit_ack = 1'b0;

    // Drain up to head 63 in dual retires
    for (int i = 9; i < 63; i++) set_entry(i, 1'b1, 1'b0, 6'(i), 32'h1000 + 32'(4 * i));
    rif.rob_tail = 7'd63;
    for (int h = 9; h < 63; h += 2)
      begin
        push(2'b11, 6'(h), 6'(h + 1), 32'h1000 + 32'(4 * h), 32'h1000 + 32'(4 * (h + 1)),
             1'b0, 6'd0);
        step();
      end

    // Wrap: head 63 (wrap 0), tail 1 (wrap 1)
    set_entry(63, 1'b1, 1'b0, 6'd33, 32'haaa0);
    set_entry(0, 1'b1, 1'b0, 6'd44, 32'hbbb0);
    rif.rob_tail = 7'b1_000001;
    #1;
    check("wrap_rd_idx0", 32'(rif.rd_idx0), 32'd63);
    check("wrap_rd_idx1", 32'(rif.rd_idx1), 32'd0);
    push(2'b11, 6'd33, 6'd44, 32'haaa0, 32'hbbb0, 1'b0, 6'd0); step();

    // Reset while waiting for a store ack
    set_entry(1, 1'b1, 1'b1, 6'd2, 32'h55);
    rif.rob_tail = 7'b1_000010;
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd1); step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_store_wait");
    for (int i = 0; i < 64; i++) set_entry(i, 1'b0, 1'b0, 6'd0, 32'd0);
    rif.rob_tail = 7'd0;
    exp_head     = 7'd0;
    exp_cnt      = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0); step();
    push(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0); step();

    // Engine is back in RUN: a plain retire goes through without an ack
    set_entry(0, 1'b1, 1'b0, 6'd17, 32'h200);
    rif.rob_tail = 7'd1;
    push(2'b01, 6'd17, 6'd0, 32'h200, 32'd0, 1'b0, 6'd0); step();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
